// File: rtl/dip_switch_bank.sv
// dip_switch_bank: synchronises and debounces NUM_BANKS active-low 8-bit switch
// groups as one vector, exposes them as inverted words plus a sticky change flag/IRQ.
module dip_switch_bank #(
   parameter int NUM_BANKS       = 8,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int ADDR_W          = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*NUM_BANKS-1:0] dip_switch,
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   we,
   input  logic [31:0]            wd,
   output logic [31:0]            RD,
   output logic                   irq
);
   localparam int                VEC_W       = 8 * NUM_BANKS;
   localparam int                NUM_WORDS   = (NUM_BANKS + 3) / 4;
   localparam int                PAD_W       = 32 * NUM_WORDS;
   localparam int                CNT_W       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_WORDS);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [VEC_W-1:0] r_s1;
   logic [VEC_W-1:0] r_s2;
   logic [VEC_W-1:0] r_cand;
   logic [VEC_W-1:0] r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ie;
   logic             r_chg;

   logic             w_pending;
   logic             w_event;
   logic             w_status_wr;
   logic [PAD_W-1:0] w_padded;
   logic             w_unused_wd;

   // A candidate that differs from the accepted value and has held for the full window.
   assign w_pending   = (r_s2 == r_cand) && (r_cand != r_stable);
   assign w_event     = w_pending && (r_cnt == CNT_LAST);
   assign w_status_wr = we && (addr == STATUS_ADDR);
   assign w_unused_wd = ^wd[31:2];

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   // NOTE: reset is synchronous; all state is individual flops (no memory array), so all of it is cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1     <= '1;
         r_s2     <= '1;
         r_cand   <= '1;
         r_stable <= '1;
         r_cnt    <= '0;
      end else begin
         r_s1 <= dip_switch;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
         end else if (w_event) begin
            r_stable <= r_cand;
            r_cnt    <= '0;
         end else if (r_cand != r_stable) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ie  <= 1'b0;
         r_chg <= 1'b0;
      end else begin
         if (w_status_wr) begin
            r_ie <= wd[0];
            if (wd[1]) r_chg <= 1'b0;
         end
         // Placed last so a change event beats a same-edge write-one-to-clear.
         if (w_event) r_chg <= 1'b1;
      end
   end

   // Absent banks are padded with "off" (ones) so they read back as zero after inversion.
   always_comb begin
      w_padded              = '1;
      w_padded[VEC_W-1:0]   = r_stable;
   end

   // NOTE: RD gets its default first so every path assigns it and no latch is inferred.
   always_comb begin
      RD = '0;
      if (!reset) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (addr == ADDR_W'(k)) RD = ~w_padded[32*k +: 32];
         end
         if (addr == STATUS_ADDR) RD = {30'd0, r_chg, r_ie};
      end
   end

   assign irq = r_ie & r_chg;

endmodule

// File: tb/tb_dip_switch_bank.sv
// Bench for dip_switch_bank: directed latency/bounce/IRQ scenarios plus randomized traffic
// against a sliding-window model, and a second instance with 6 banks.
module tb_dip_switch_bank;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] dip_switch = '1;
   logic [2:0]  addr = '0;
   logic        we = 1'b0;
   logic [31:0] wd = '0;
   logic [31:0] RD;
   logic        irq;

   logic        reset6 = 1'b1;
   logic [47:0] dip6 = '1;
   logic [1:0]  addr6 = '0;
   logic        we6 = 1'b0;
   logic [31:0] wd6 = '0;
   logic [31:0] RD6;
   logic        irq6;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dip_switch_bank #(.NUM_BANKS(8), .DEBOUNCE_CYCLES(D), .ADDR_W(3)) u_dut (
      .clk(clk), .reset(reset), .dip_switch(dip_switch), .addr(addr),
      .we(we), .wd(wd), .RD(RD), .irq(irq)
   );

   dip_switch_bank #(.NUM_BANKS(6), .DEBOUNCE_CYCLES(D), .ADDR_W(2)) u_dut6 (
      .clk(clk), .reset(reset6), .dip_switch(dip6), .addr(addr6),
      .we(we6), .wd(wd6), .RD(RD6), .irq(irq6)
   );

   // Model: a value is accepted once the synchronised sample (raw seen two edges earlier)
   // has been identical for D+1 consecutive edges and differs from the accepted value.
   logic [63:0] m_hist[$];
   logic [63:0] m_stable;
   logic        m_ie;
   logic        m_chg;

   always @(posedge clk) begin
      logic        ev;
      logic [63:0] v;
      if (reset) begin
         m_hist = {};
         for (int i = 0; i < D + 3; i++) m_hist.push_back('1);
         m_stable = '1;
         m_ie     = 1'b0;
         m_chg    = 1'b0;
      end else begin
         m_hist.push_front(dip_switch);
         void'(m_hist.pop_back());
         v  = m_hist[2];
         ev = (v != m_stable);
         for (int j = 0; j <= D; j++) if (m_hist[2+j] != v) ev = 1'b0;
         if (we && addr == 3'd2) begin
            m_ie = wd[0];
            if (wd[1]) m_chg = 1'b0;
         end
         if (ev) begin
            m_stable = v;
            m_chg    = 1'b1;
         end
      end
   end

   function automatic logic [31:0] exp_rd(input logic [2:0] a);
      if (reset) return 32'h0;
      case (a)
         3'd0:    return ~m_stable[31:0];
         3'd1:    return ~m_stable[63:32];
         3'd2:    return {30'd0, m_chg, m_ie};
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      dip_switch = '1;
      we         = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic write_status(input logic [31:0] data);
      we   = 1'b1;
      addr = 3'd2;
      wd   = data;
      tick();
      we = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < 8; a++) begin
         addr = 3'(a);
         #1;
         n_tests++;
         if (RD !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read addr %0d: got %h want 00000000", a, RD);
         end
      end
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      dip_switch = '0;
      for (int e = 0; e < D + 4; e++) tick();
      addr = 3'd0;
      #1;
      n_tests++;
      if (RD !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL all_on_word0: got %h want ffffffff", RD);
      end
      reset = 1'b1;
      for (int a = 0; a < 8; a++) begin
         addr = 3'(a);
         #1;
         n_tests++;
         if (RD !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_during_reset addr %0d: got %h want 00000000", a, RD);
         end
      end
      do_reset();
   endtask

   task automatic test_bank0_latency();
      logic [31:0] exp;
      do_reset();
      dip_switch[7:0] = 8'hFE;
      for (int e = 1; e <= D + 3; e++) begin
         tick();
         addr = 3'd0;
         #1;
         exp = (e == D + 3) ? 32'h1 : 32'h0;
         n_tests++;
         if (RD !== exp) begin
            n_fail++;
            $display("FAIL bank0_latency edge %0d: got %h want %h", e, RD, exp);
         end
         addr = 3'd2;
         #1;
         exp = (e == D + 3) ? 32'h2 : 32'h0;
         n_tests++;
         if (RD !== exp) begin
            n_fail++;
            $display("FAIL bank0_status edge %0d: got %h want %h", e, RD, exp);
         end
      end
   endtask

   task automatic test_bank7();
      do_reset();
      dip_switch[63:56] = 8'h7F;
      for (int e = 1; e <= D + 3; e++) begin
         tick();
         addr = 3'd1;
         #1;
         n_tests++;
         if (RD !== ((e == D + 3) ? 32'h8000_0000 : 32'h0)) begin
            n_fail++;
            $display("FAIL bank7_word1 edge %0d: got %h", e, RD);
         end
      end
      addr = 3'd0;
      #1;
      n_tests++;
      if (RD !== 32'h0) begin
         n_fail++;
         $display("FAIL bank7_word0: got %h want 00000000", RD);
      end
   endtask

   task automatic test_bounce();
      logic [31:0] exp;
      do_reset();
      for (int e = 1; e <= 22; e++) begin
         // Five toggles of bank 3 bit 0, the last one (to low) before edge 9.
         if (e <= 10 && (e % 2) == 1) dip_switch[24] = ~dip_switch[24];
         if (e == 19) write_status(32'h2);
         else tick();
         addr = 3'd0;
         #1;
         exp = (e >= 15) ? 32'h0100_0000 : 32'h0;
         n_tests++;
         if (RD !== exp || RD !== exp_rd(3'd0)) begin
            n_fail++;
            $display("FAIL bounce_word0 edge %0d: got %h want %h", e, RD, exp);
         end
         addr = 3'd2;
         #1;
         exp = (e >= 15 && e < 19) ? 32'h2 : 32'h0;
         n_tests++;
         if (RD !== exp) begin
            n_fail++;
            $display("FAIL bounce_chg edge %0d: got %h want %h", e, RD, exp);
         end
      end
   endtask

   task automatic test_irq();
      do_reset();
      write_status(32'h1);
      addr = 3'd2;
      #1;
      n_tests++;
      if (RD !== 32'h1 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_enable: RD=%h irq=%b want 00000001/0", RD, irq);
      end
      dip_switch[15:8] = 8'h00;
      for (int e = 1; e <= D + 3; e++) begin
         tick();
         #1;
         n_tests++;
         if (irq !== (e == D + 3)) begin
            n_fail++;
            $display("FAIL irq_rise edge %0d: got %b", e, irq);
         end
      end
      write_status(32'h3);
      addr = 3'd2;
      #1;
      n_tests++;
      if (RD !== 32'h1 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_w1c: RD=%h irq=%b want 00000001/0", RD, irq);
      end
      dip_switch[15:8] = 8'hFF;
      for (int e = 1; e < D + 3; e++) tick();
      write_status(32'h3);
      addr = 3'd2;
      #1;
      n_tests++;
      if (RD !== 32'h3 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set_wins: RD=%h irq=%b want 00000003/1", RD, irq);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) dip_switch = {$urandom, $urandom};
            else dip_switch[$urandom_range(0, 63)] ^= 1'b1;
         end
         reset = ($urandom_range(0, 299) == 0);
         we    = ($urandom_range(0, 5) == 0);
         addr  = 3'($urandom_range(0, 7));
         wd    = $urandom;
         tick();
         we   = 1'b0;
         addr = 3'($urandom_range(0, 7));
         #1;
         n_tests++;
         if (RD !== exp_rd(addr) || irq !== (m_ie & m_chg)) begin
            n_fail++;
            $display("FAIL random cycle %0d addr %0d: RD=%h irq=%b want %h/%b",
                     c, addr, RD, irq, exp_rd(addr), m_ie & m_chg);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_six_banks();
      logic [31:0] want [4];
      want = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h2, 32'h0};
      reset6 = 1'b1;
      dip6   = '1;
      tick();
      tick();
      reset6 = 1'b0;
      dip6   = '0;
      for (int e = 1; e <= D + 3; e++) begin
         tick();
         addr6 = 2'd1;
         #1;
         n_tests++;
         if (RD6 !== ((e == D + 3) ? 32'h0000_FFFF : 32'h0)) begin
            n_fail++;
            $display("FAIL six_word1 edge %0d: got %h", e, RD6);
         end
      end
      for (int a = 0; a < 4; a++) begin
         addr6 = 2'(a);
         #1;
         n_tests++;
         if (RD6 !== want[a]) begin
            n_fail++;
            $display("FAIL six_map addr %0d: got %h want %h", a, RD6, want[a]);
         end
      end
   endtask

   task automatic test_six_reset_mid();
      reset6 = 1'b1;
      dip6   = '1;
      tick();
      tick();
      reset6     = 1'b0;
      dip6[7:0]  = 8'hFE;
      // After edge 5 the count sits at 2.
      for (int e = 1; e <= 5; e++) tick();
      addr6 = 2'd0;
      #1;
      n_tests++;
      if (RD6 !== 32'h0) begin
         n_fail++;
         $display("FAIL six_pre_reset: got %h want 00000000", RD6);
      end
      reset6 = 1'b1;
      dip6   = '1;
      for (int a = 0; a < 4; a++) begin
         addr6 = 2'(a);
         #1;
         n_tests++;
         if (RD6 !== 32'h0) begin
            n_fail++;
            $display("FAIL six_rd_in_reset addr %0d: got %h", a, RD6);
         end
      end
      tick();
      tick();
      reset6 = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         addr6 = 2'd2;
         #1;
         n_tests++;
         if (RD6 !== 32'h0 || irq6 !== 1'b0) begin
            n_fail++;
            $display("FAIL six_no_event edge %0d: status=%h irq=%b", e, RD6, irq6);
         end
         addr6 = 2'd0;
         #1;
         n_tests++;
         if (RD6 !== 32'h0) begin
            n_fail++;
            $display("FAIL six_word0_after edge %0d: got %h", e, RD6);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_bank0_latency();
      test_bank7();
      test_bounce();
      test_irq();
      test_random();
      test_six_banks();
      test_six_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dip_switch_bank.md
# dip_switch_bank

Parametrised DIP-switch input peripheral for the MIPS system bridge: the next generation of the 64-bit switch block. It takes `NUM_BANKS` active-low 8-bit switch groups and synchronises and debounces them as one vector. Software reads them as inverted 32-bit words. It also provides a sticky change flag with an interrupt line, so software no longer has to poll. It sits on the bridge as a word-addressed device beside the timer and LED peripherals.

## Interface
- `NUM_BANKS`, default 8: number of 8-bit switch groups (1..32).
- `DEBOUNCE_CYCLES`, default 1000: stable cycles required before accepting a new value (≥1).
- `ADDR_W`, default 3: word-address width. Must satisfy 2^ADDR_W ≥ NUM_WORDS+1.
- Derived: `NUM_WORDS` = ceil(NUM_BANKS/4). `STATUS_ADDR` = NUM_WORDS.
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dip_switch` input 8*NUM_BANKS: raw switch levels, asynchronous, active-low. Bank b is bits [8b+7:8b].
- `addr` input ADDR_W: word address from the bridge.
- `we` input 1: write strobe, one cycle per write.
- `wd` input 32: write data.
- `RD` output 32: read data, combinational from `addr` and registers.
- `irq` output 1: interrupt request, level-sensitive.

## Operation
- Input path: `s1` <= `dip_switch`, then `s2` <= `s1` (2-flop synchroniser). Both cover the full vector.
- Debounce uses `cand` (candidate), `stable` (accepted value) and `cnt` (width clog2(DEBOUNCE_CYCLES)+1). Each edge, in priority order:
  - If `s2` != `cand`: `cand` <= `s2`, `cnt` <= 0.
  - Else if `cand` != `stable` and `cnt` == DEBOUNCE_CYCLES-1: `stable` <= `cand`, `cnt` <= 0, change event.
  - Else if `cand` != `stable`: `cnt` <= `cnt`+1.
  - Else: `cnt` <= 0.
- Any new bounce restarts the count.
- The whole vector is debounced as one unit. A change in any bank restarts the count for all banks.
- Data words, for k < NUM_WORDS: `RD` = ~{bank 4k+3, 4k+2, 4k+1, 4k} taken from `stable`.
  - Banks at or above NUM_BANKS read as 0 (after inversion), not 1.
- Status word, at `STATUS_ADDR`:
  - Bit 0 is IE, read/write.
  - Bit 1 is CHG, sticky; writing 1 clears it, writing 0 has no effect.
  - Bits 31:2 read 0.
- Any other address reads 0. Writes to data words or unmapped addresses are ignored.
- CHG is set by a change event. A simultaneous event and W1C leave CHG = 1 (set wins).
- A write with `we` and `wd[0]` updates IE in the same edge as any W1C of CHG.
- `irq` = IE & CHG, combinational from registers.

## Timing
- Reset values:
  - `s1`, `s2`, `cand`, `stable` all ones (all switches off).
  - `cnt` = 0, IE = 0, CHG = 0, so `irq` = 0.
  - `RD` = 0 while `reset` is high, independent of `addr`.
- Reset mid-debounce discards `cand` and `cnt`; no change event is produced.
- After reset, switches held on are seen as a change. They are accepted after the normal latency and set CHG.
- Latency: a raw level held from edge 1 becomes visible in `RD` after edge DEBOUNCE_CYCLES+3, and CHG rises on that same edge.
  - With DEBOUNCE_CYCLES=1 this is edge 4.
- A raw transition that reverts before `stable` updates produces no event and no change in `RD`.
- Register writes take effect on the edge with `we`=1. They are visible in `RD` and `irq` in the next cycle.
- `RD` has no read side effects. Reads never clear CHG.

## Test plan
- Setup for all scenarios: NUM_BANKS=8, DEBOUNCE_CYCLES=4, ADDR_W=3.
- Reset with raw all 8'hFF:
  - addr 0 and 1 read 0x00000000, addr 2 reads 0, `irq`=0.
  - Addr 3..7 read 0.
  - `RD`=0 during `reset` even with stable on.
- Bank 0 raw to 8'hFE held from edge 1:
  - addr 0 still 0 after edge 6; reads 0x00000001 after edge 7.
  - addr 2 reads 0x2 after edge 7.
- Bank 7 raw to 8'h7F: addr 1 reads 0x80000000 after DEBOUNCE_CYCLES+3 edges; addr 0 unchanged.
- Bounce: toggle bank 3 bit 0 every 2 cycles for 10 cycles, then hold low:
  - exactly one change event;
  - addr 0 reads 0x01000000 exactly 7 edges after the last raw transition.
- Interrupts:
  - write 0x1 to addr 2, then trigger a change: `irq` rises with CHG;
  - write 0x3: CHG clears, `irq` falls, IE stays 1;
  - a W1C on the same edge as a change event leaves CHG=1 and `irq`=1.
- NUM_BANKS=6, ADDR_W=2:
  - all banks on gives addr 1 = 0x0000FFFF;
  - status at addr 2, addr 3 reads 0;
  - `reset` asserted at `cnt`=2 gives no event, CHG=0 and `RD`=0.
